btn_press_gen: RTL and testbench
================================

BTN_PRESS_GEN -- requirements
Module: btn_press_gen

Interface
REQ-001 SHALL have parameter TICK_DIV, default 100, clk cycles per timing tick (>=2).
REQ-002 SHALL have parameter HOLD_TICKS, default 50, ticks out_btn is held high per press (>=1).
REQ-003 SHALL have parameter GAP_TICKS, default 10, ticks out_btn is held low after each press (>=1).
REQ-004 SHALL have port clk  input  1  single system clock; all logic on its rising edge.
REQ-005 SHALL have port rst  input  1  reset; synchronous and active-high.
REQ-006 SHALL have port in_pulse  input  1  one-cycle press request, synchronous to clk.
REQ-007 SHALL have port out_btn  output  1  clean button-level output, registered.
REQ-008 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-009 SHALL have port pend_cnt  output  3  queued requests not yet replayed.
REQ-010 SHALL have port ovf  output  1  sticky flag, a request was dropped because the queue was full.

Function
REQ-011 SHALL implement a three-state FSM: IDLE, HOLD, GAP.
REQ-012 Prescaler SHALL count 0..TICK_DIV-1 and emit a one-cycle tick at TICK_DIV-1; it SHALL be cleared on every IDLE->HOLD and HOLD->GAP transition.
REQ-013 IDLE: out_btn=0; in_pulse=1 or pend_cnt>0 SHALL move to HOLD at the next edge.
REQ-014 out_btn SHALL rise in the cycle after in_pulse is sampled in IDLE (latency 1 cycle).
REQ-015 HOLD: out_btn=1 for exactly HOLD_TICKS*TICK_DIV cycles, then GAP.
REQ-016 GAP: out_btn=0 for exactly GAP_TICKS*TICK_DIV cycles, then IDLE.
REQ-017 busy SHALL be combinationally equal to (state != IDLE).
REQ-018 Leaving IDLE because pend_cnt>0 with in_pulse=0 SHALL decrement pend_cnt by 1.
REQ-019 in_pulse=1 in HOLD or GAP SHALL increment pend_cnt, saturating at 7.
REQ-020 in_pulse=1 in IDLE with pend_cnt>0 SHALL start HOLD and leave pend_cnt unchanged.
REQ-021 in_pulse=1 while pend_cnt=7 and state!=IDLE SHALL drop the request and set ovf=1.
REQ-022 Once set, ovf SHALL stay 1 until rst.
REQ-023 in_pulse held high for several cycles SHALL count as one request per cycle (no edge detection inside).
REQ-024 A replayed press SHALL have the same HOLD and GAP timing as a direct one.

Reset
REQ-025 rst=1 at a clock edge SHALL force state=IDLE, prescaler=0, out_btn=0, pend_cnt=0, ovf=0.
REQ-026 rst in HOLD or GAP SHALL abort the press immediately (out_btn=0 after that edge); queued requests SHALL be discarded.
REQ-027 rst SHALL take priority over in_pulse in the same cycle.

Configuration
REQ-028 Macro BTN_PRESS_GEN_QUEUE_EN defined: queue behaviour per REQ-018..REQ-021.
REQ-029 Macro BTN_PRESS_GEN_QUEUE_EN undefined: in_pulse outside IDLE SHALL be ignored and SHALL set ovf; pend_cnt SHALL be tied to 0; no queue register.

Verification (TICK_DIV=4, HOLD_TICKS=3, GAP_TICKS=2, queue enabled unless noted)
REQ-030 Single in_pulse at cycle 10 -> out_btn=1 cycles 11..22, 0 cycles 23..30, busy=0 from cycle 31.
REQ-031 in_pulse at cycles 10, 15, 25 -> pend_cnt reaches 2; second press out_btn=1 cycles 32..43; third press out_btn=1 cycles 53..64; pend_cnt=0 after cycle 52.
REQ-032 In HOLD, nine in_pulse cycles -> pend_cnt saturates at 7; ovf=1 after the 8th and stays 1 until rst.
REQ-033 rst asserted 5 cycles into HOLD with pend_cnt=3 -> next cycle: out_btn=0, busy=0, pend_cnt=0, ovf=0.
REQ-034 Queue disabled: in_pulse at cycles 10 and 15 -> only one press (cycles 11..22); ovf=1 from cycle 16.
REQ-035 in_pulse in the cycle busy falls while pend_cnt=1 -> HOLD starts next cycle and pend_cnt stays 1.

Source files
------------

// File: rtl/btn_press_gen.sv
`default_nettype none
// ============================================================================
// Module      : btn_press_gen
// Description : Turns one-cycle press requests into timed button presses
//               (HOLD high, then GAP low) with an optional 7-deep request
//               queue enabled by the BTN_PRESS_GEN_QUEUE_EN macro.
// Revision    : 1.0 - initial release
// ============================================================================
module btn_press_gen #(
    parameter int TICK_DIV   = 100,
    parameter int HOLD_TICKS = 50,
    parameter int GAP_TICKS  = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_pulse,
    output logic       out_btn,
    output logic       busy,
    output logic [2:0] pend_cnt,
    output logic       ovf
);

    localparam int c_PRESC_W  = $clog2(TICK_DIV);
    localparam int c_TICK_MAX = (HOLD_TICKS > GAP_TICKS) ? HOLD_TICKS : GAP_TICKS;
    localparam int c_TICK_W   = (c_TICK_MAX > 1) ? $clog2(c_TICK_MAX) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    state_t                 r_state;
    logic [c_PRESC_W-1:0]   r_presc;
    logic [c_TICK_W-1:0]    r_ticks;
    logic                   r_out;
    logic                   r_ovf;
    logic                   w_tick;
    logic                   w_drop;

    assign w_tick  = (r_presc == c_PRESC_W'(TICK_DIV - 1));
    assign busy    = (r_state != ST_IDLE);
    assign out_btn = r_out;
    assign ovf     = r_ovf;

`ifdef BTN_PRESS_GEN_QUEUE_EN
    logic [2:0] r_pend;

    // A request arriving in IDLE starts the press directly, so it neither
    // consumes nor adds a queue entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pend <= 3'd0;
        end else if (r_state == ST_IDLE) begin
            if (!in_pulse && r_pend != 3'd0)
                r_pend <= r_pend - 3'd1;
        end else if (in_pulse && r_pend != 3'd7) begin
            r_pend <= r_pend + 3'd1;
        end
    end

    assign pend_cnt = r_pend;
    assign w_drop   = (r_state != ST_IDLE) && in_pulse && (r_pend == 3'd7);
`else
    assign pend_cnt = 3'd0;
    assign w_drop   = (r_state != ST_IDLE) && in_pulse;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_presc <= '0;
            r_ticks <= '0;
            r_out   <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_presc <= w_tick ? '0 : r_presc + 1'b1;
            if (w_drop)
                r_ovf <= 1'b1;

            case (r_state)
                ST_IDLE: begin
                    if (in_pulse || pend_cnt != 3'd0) begin
                        r_state <= ST_HOLD;
                        r_out   <= 1'b1;
                        r_presc <= '0;
                        r_ticks <= '0;
                    end
                end
                ST_HOLD: begin
                    if (w_tick) begin
                        if (r_ticks == c_TICK_W'(HOLD_TICKS - 1)) begin
                            r_state <= ST_GAP;
                            r_out   <= 1'b0;
                            r_ticks <= '0;
                        end else begin
                            r_ticks <= r_ticks + 1'b1;
                        end
                    end
                end
                ST_GAP: begin
                    if (w_tick) begin
                        if (r_ticks == c_TICK_W'(GAP_TICKS - 1)) begin
                            r_state <= ST_IDLE;
                            r_ticks <= '0;
                        end else begin
                            r_ticks <= r_ticks + 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_out   <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_btn_press_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_btn_press_gen
// Description : Directed self-checking bench for btn_press_gen
//               (TICK_DIV=4, HOLD_TICKS=3, GAP_TICKS=2).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_btn_press_gen;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       in_pulse = 1'b0;
    logic       out_btn;
    logic       busy;
    logic [2:0] pend_cnt;
    logic       ovf;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;

`ifdef BTN_PRESS_GEN_QUEUE_EN
    localparam bit c_QUEUE = 1'b1;
`else
    localparam bit c_QUEUE = 1'b0;
`endif

    btn_press_gen #(.TICK_DIV(4), .HOLD_TICKS(3), .GAP_TICKS(2)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_pulse (in_pulse),
        .out_btn  (out_btn),
        .busy     (busy),
        .pend_cnt (pend_cnt),
        .ovf      (ovf)
    );

    always #5 clk = ~clk;

    // Advance one clock; afterwards we are in cycle cyc, sampled 1ns past the edge.
    task automatic step(input logic p);
        in_pulse = p;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(1'b0);
        rst = 1'b0;
        cyc = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(1'b1);
        rst = 1'b0;
        n_cmp++; if (out_btn !== 1'b0)  begin n_fail++; $display("FAIL reset out_btn: got %b want 0", out_btn); end
        n_cmp++; if (busy !== 1'b0)     begin n_fail++; $display("FAIL reset busy: got %b want 0", busy); end
        n_cmp++; if (pend_cnt !== 3'd0) begin n_fail++; $display("FAIL reset pend_cnt: got %0d want 0", pend_cnt); end
        n_cmp++; if (ovf !== 1'b0)      begin n_fail++; $display("FAIL reset ovf: got %b want 0", ovf); end
    endtask

    task automatic test_single();
        logic e_out, e_busy;
        do_reset();
        for (int c = 0; c <= 32; c++) begin
            step(c == 10);
            e_out  = (cyc >= 11 && cyc <= 22);
            e_busy = (cyc >= 11 && cyc <= 30);
            n_cmp++; if (out_btn !== e_out) begin n_fail++; $display("FAIL single out_btn cyc %0d: got %b want %b", cyc, out_btn, e_out); end
            n_cmp++; if (busy !== e_busy)   begin n_fail++; $display("FAIL single busy cyc %0d: got %b want %b", cyc, busy, e_busy); end
        end
    endtask

    task automatic test_queue();
        logic e_out, e_busy;
        logic [2:0] e_pend;
        do_reset();
        for (int c = 0; c <= 74; c++) begin
            step(c == 10 || c == 15 || c == 25);
            e_out  = (cyc >= 11 && cyc <= 22) || (cyc >= 32 && cyc <= 43) || (cyc >= 53 && cyc <= 64);
            e_busy = (cyc >= 11 && cyc <= 72) && cyc != 31 && cyc != 52;
            e_pend = (cyc <= 15) ? 3'd0 : (cyc <= 25) ? 3'd1 : (cyc <= 31) ? 3'd2 : (cyc <= 52) ? 3'd1 : 3'd0;
            n_cmp++; if (out_btn !== e_out)   begin n_fail++; $display("FAIL queue out_btn cyc %0d: got %b want %b", cyc, out_btn, e_out); end
            n_cmp++; if (busy !== e_busy)     begin n_fail++; $display("FAIL queue busy cyc %0d: got %b want %b", cyc, busy, e_busy); end
            n_cmp++; if (pend_cnt !== e_pend) begin n_fail++; $display("FAIL queue pend_cnt cyc %0d: got %0d want %0d", cyc, pend_cnt, e_pend); end
        end
        n_cmp++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL queue ovf: got %b want 0", ovf); end
    endtask

    task automatic test_saturate();
        logic       e_ovf;
        logic [2:0] e_pend;
        do_reset();
        for (int c = 0; c <= 20; c++) begin
            step(c >= 10 && c <= 19);
            if (cyc >= 12) begin
                e_pend = (cyc - 11 >= 7) ? 3'd7 : 3'(cyc - 11);
                e_ovf  = (cyc >= 19);
                n_cmp++; if (pend_cnt !== e_pend) begin n_fail++; $display("FAIL sat pend_cnt cyc %0d: got %0d want %0d", cyc, pend_cnt, e_pend); end
                n_cmp++; if (ovf !== e_ovf)       begin n_fail++; $display("FAIL sat ovf cyc %0d: got %b want %b", cyc, ovf, e_ovf); end
            end
        end
        // Reset with a simultaneous request, while still in HOLD with ovf set.
        rst = 1'b1;
        step(1'b1);
        rst = 1'b0;
        n_cmp++; if (out_btn !== 1'b0)  begin n_fail++; $display("FAIL sat_rst out_btn: got %b want 0", out_btn); end
        n_cmp++; if (pend_cnt !== 3'd0) begin n_fail++; $display("FAIL sat_rst pend_cnt: got %0d want 0", pend_cnt); end
        n_cmp++; if (ovf !== 1'b0)      begin n_fail++; $display("FAIL sat_rst ovf: got %b want 0", ovf); end
    endtask

    task automatic test_abort();
        logic [2:0] e_pend;
        do_reset();
        for (int c = 0; c <= 14; c++)
            step(c >= 10 && c <= 13);
        e_pend = c_QUEUE ? 3'd3 : 3'd0;
        n_cmp++; if (pend_cnt !== e_pend)  begin n_fail++; $display("FAIL abort pre pend_cnt: got %0d want %0d", pend_cnt, e_pend); end
        n_cmp++; if (ovf !== !c_QUEUE)     begin n_fail++; $display("FAIL abort pre ovf: got %b want %b", ovf, !c_QUEUE); end
        n_cmp++; if (out_btn !== 1'b1)     begin n_fail++; $display("FAIL abort pre out_btn: got %b want 1", out_btn); end
        rst = 1'b1;
        step(1'b1);
        rst = 1'b0;
        n_cmp++; if (out_btn !== 1'b0)  begin n_fail++; $display("FAIL abort out_btn: got %b want 0", out_btn); end
        n_cmp++; if (busy !== 1'b0)     begin n_fail++; $display("FAIL abort busy: got %b want 0", busy); end
        n_cmp++; if (pend_cnt !== 3'd0) begin n_fail++; $display("FAIL abort pend_cnt: got %0d want 0", pend_cnt); end
        n_cmp++; if (ovf !== 1'b0)      begin n_fail++; $display("FAIL abort ovf: got %b want 0", ovf); end
        // The aborted press must not resume once reset is released.
        step(1'b0);
        n_cmp++; if (busy !== 1'b0)     begin n_fail++; $display("FAIL abort idle busy: got %b want 0", busy); end
    endtask

    task automatic test_back_to_back();
        logic e_out, e_busy;
        logic [2:0] e_pend;
        do_reset();
        for (int c = 0; c <= 65; c++) begin
            step(c == 10 || c == 15 || c == 31);
            e_out  = (cyc >= 11 && cyc <= 22) || (cyc >= 32 && cyc <= 43) || (cyc >= 53 && cyc <= 64);
            e_busy = (cyc >= 11) && cyc != 31 && cyc != 52;
            e_pend = (cyc <= 15) ? 3'd0 : (cyc <= 52) ? 3'd1 : 3'd0;
            n_cmp++; if (out_btn !== e_out)   begin n_fail++; $display("FAIL b2b out_btn cyc %0d: got %b want %b", cyc, out_btn, e_out); end
            n_cmp++; if (busy !== e_busy)     begin n_fail++; $display("FAIL b2b busy cyc %0d: got %b want %b", cyc, busy, e_busy); end
            n_cmp++; if (pend_cnt !== e_pend) begin n_fail++; $display("FAIL b2b pend_cnt cyc %0d: got %0d want %0d", cyc, pend_cnt, e_pend); end
        end
    endtask

    task automatic test_no_queue();
        logic e_out, e_ovf;
        do_reset();
        for (int c = 0; c <= 40; c++) begin
            step(c == 10 || c == 15);
            e_out = (cyc >= 11 && cyc <= 22);
            e_ovf = (cyc >= 16);
            n_cmp++; if (out_btn !== e_out)   begin n_fail++; $display("FAIL noq out_btn cyc %0d: got %b want %b", cyc, out_btn, e_out); end
            n_cmp++; if (ovf !== e_ovf)       begin n_fail++; $display("FAIL noq ovf cyc %0d: got %b want %b", cyc, ovf, e_ovf); end
            n_cmp++; if (pend_cnt !== 3'd0)   begin n_fail++; $display("FAIL noq pend_cnt cyc %0d: got %0d want 0", cyc, pend_cnt); end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_abort();
`ifdef BTN_PRESS_GEN_QUEUE_EN
        test_queue();
        test_saturate();
        test_back_to_back();
`else
        test_no_queue();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
